// File: rtl/cf_sweep_ctrl.sv
// Built-in self-check sequencer: sweeps every input vector of a small combinational
// block, captures its truth table and compares it against an expected table.
module cf_sweep_ctrl #(
    parameter int unsigned N_IN   = 5,
    parameter int unsigned SETTLE = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    abort,
    input  logic [(1<<N_IN)-1:0]    expected,
    input  logic                    y_in,
    output logic [N_IN-1:0]         vec_out,
    output logic                    busy,
    output logic                    done,
    output logic                    pass,
    output logic [(1<<N_IN)-1:0]    table_out,
    output logic [N_IN:0]           mismatch_cnt,
    output logic [N_IN-1:0]         first_fail,
    output logic                    first_fail_valid
);

    localparam int unsigned N_VEC = 1 << N_IN;
    localparam int unsigned VW    = N_IN;
    localparam int unsigned MW    = N_IN + 1;
    localparam int unsigned CW    = 4;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_SAMPLE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   settle_cnt;
    logic            last_vec_c;
    logic            miss_c;

    assign last_vec_c = (vec_out == VW'(N_VEC - 1));
    assign miss_c     = (y_in != expected[vec_out]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next-state decode; abort cancels from any active state
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:   if (start && !abort) state_nxt = S_WAIT;
            S_WAIT: begin
                if (abort)                 state_nxt = S_IDLE;
                else if (settle_cnt == '0) state_nxt = S_SAMPLE;
            end
            S_SAMPLE: begin
                if (abort)           state_nxt = S_IDLE;
                else if (last_vec_c) state_nxt = S_DONE;
                else                 state_nxt = S_WAIT;
            end
            S_DONE:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Datapath and registered status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec_out          <= '0;
            settle_cnt       <= '0;
            busy             <= 1'b0;
            done             <= 1'b0;
            pass             <= 1'b0;
            table_out        <= '0;
            mismatch_cnt     <= '0;
            first_fail       <= '0;
            first_fail_valid <= 1'b0;
        end else begin
            busy <= (state_nxt == S_WAIT) || (state_nxt == S_SAMPLE);
            done <= (state_nxt == S_DONE);
            if (abort && state != S_IDLE) begin
                vec_out <= '0;
                pass    <= 1'b0;
            end else begin
                unique case (state)
                    S_IDLE: begin
                        if (start && !abort) begin
                            vec_out          <= '0;
                            settle_cnt       <= CW'(SETTLE - 1);
                            pass             <= 1'b0;
                            table_out        <= '0;
                            mismatch_cnt     <= '0;
                            first_fail       <= '0;
                            first_fail_valid <= 1'b0;
                        end
                    end
                    S_WAIT: begin
                        if (settle_cnt != '0) settle_cnt <= settle_cnt - CW'(1);
                    end
                    S_SAMPLE: begin
                        table_out[vec_out] <= y_in;
                        if (miss_c) begin
                            mismatch_cnt <= mismatch_cnt + MW'(1);
                            if (!first_fail_valid) begin
                                first_fail       <= vec_out;
                                first_fail_valid <= 1'b1;
                            end
                        end
                        if (last_vec_c) begin
                            pass <= (mismatch_cnt == '0) && !miss_c;
                        end else begin
                            vec_out    <= vec_out + VW'(1);
                            settle_cnt <= CW'(SETTLE - 1);
                        end
                    end
                    S_DONE:  vec_out <= '0;
                    default: vec_out <= '0;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_cf_sweep_ctrl.sv
// Directed bench for cf_sweep_ctrl: default 5-input/1-settle instance plus a
// 3-input/3-settle instance, each driven by a small function-block model.
module tb_cf_sweep_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Default instance
    logic        start5, abort5, y5;
    logic [31:0] exp5, table5;
    logic [4:0]  vec5, ff5;
    logic [5:0]  mm5;
    logic        busy5, done5, pass5, ffv5;
    int          y_mode;

    always_comb begin
        case (y_mode)
            1:       y5 = 1'b0;
            2:       y5 = 1'b1;
            default: y5 = ^vec5;
        endcase
    end

    cf_sweep_ctrl dut5 (
        .clk(clk), .rst_n(rst_n), .start(start5), .abort(abort5),
        .expected(exp5), .y_in(y5), .vec_out(vec5), .busy(busy5), .done(done5),
        .pass(pass5), .table_out(table5), .mismatch_cnt(mm5), .first_fail(ff5),
        .first_fail_valid(ffv5)
    );

    // Small instance: 3 inputs, 3 settle cycles, AND function
    logic        start3, abort3, y3;
    logic [7:0]  exp3, table3;
    logic [2:0]  vec3, ff3;
    logic [3:0]  mm3;
    logic        busy3, done3, pass3, ffv3;

    assign y3 = &vec3;

    cf_sweep_ctrl #(.N_IN(3), .SETTLE(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .abort(abort3),
        .expected(exp3), .y_in(y3), .vec_out(vec3), .busy(busy3), .done(done3),
        .pass(pass3), .table_out(table3), .mismatch_cnt(mm3), .first_fail(ff3),
        .first_fail_valid(ffv3)
    );

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Called at posedge+1; returns just after the start-accepting edge
    task automatic pulse_start5();
        start5 = 1'b1;
        step(1);
        start5 = 1'b0;
    endtask

    task automatic test_reset();
        n_checks++;
        if ({vec5, busy5, done5, pass5, table5, mm5, ff5, ffv5} !== '0) begin
            n_fail++;
            $display("FAIL reset_dut5: vec=%0d busy=%b done=%b pass=%b table=%h mm=%0d ff=%0d ffv=%b, want all 0",
                     vec5, busy5, done5, pass5, table5, mm5, ff5, ffv5);
        end
        n_checks++;
        if ({vec3, busy3, done3, pass3, table3, mm3, ff3, ffv3} !== '0) begin
            n_fail++;
            $display("FAIL reset_dut3: nonzero outputs after reset, want all 0");
        end
    endtask

    task automatic test_xor_sweep();
        int bad;
        y_mode = 0;
        exp5   = 32'h9669_6996;
        pulse_start5();
        bad = 0;
        for (int k = 0; k < 64; k++) begin
            n_checks++;
            if (vec5 !== 5'(k >> 1) || busy5 !== 1'b1 || done5 !== 1'b0) begin
                n_fail++;
                bad++;
                if (bad < 5)
                    $display("FAIL xor_walk cyc %0d: vec=%0d busy=%b done=%b, want vec=%0d busy=1 done=0",
                             k, vec5, busy5, done5, k >> 1);
            end
            step(1);
        end
        n_checks++;
        if (done5 !== 1'b1 || busy5 !== 1'b0 || pass5 !== 1'b1 || table5 !== 32'h9669_6996
            || mm5 !== 6'd0 || ffv5 !== 1'b0) begin
            n_fail++;
            $display("FAIL xor_done: done=%b busy=%b pass=%b table=%h mm=%0d ffv=%b, want 1 0 1 96696996 0 0",
                     done5, busy5, pass5, table5, mm5, ffv5);
        end
        step(1);
        n_checks++;
        if (done5 !== 1'b0 || vec5 !== 5'd0 || pass5 !== 1'b1) begin
            n_fail++;
            $display("FAIL xor_after: done=%b vec=%0d pass=%b, want done=0 vec=0 pass=1", done5, vec5, pass5);
        end
    endtask

    task automatic test_stuck0();
        y_mode = 1;
        exp5   = 32'h9669_6996;
        pulse_start5();
        n_checks++;
        if (pass5 !== 1'b0) begin
            n_fail++;
            $display("FAIL stuck0_pass_clear: pass=%b, want 0 after start", pass5);
        end
        step(64);
        n_checks++;
        if (done5 !== 1'b1 || pass5 !== 1'b0 || table5 !== 32'h0 || mm5 !== 6'd16
            || ff5 !== 5'd1 || ffv5 !== 1'b1) begin
            n_fail++;
            $display("FAIL stuck0: done=%b pass=%b table=%h mm=%0d ff=%0d ffv=%b, want 1 0 0 16 1 1",
                     done5, pass5, table5, mm5, ff5, ffv5);
        end
        step(5);
        n_checks++;
        if (mm5 !== 6'd16 || ff5 !== 5'd1 || busy5 !== 1'b0) begin
            n_fail++;
            $display("FAIL stuck0_hold: mm=%0d ff=%0d busy=%b, want 16 1 0", mm5, ff5, busy5);
        end
    endtask

    task automatic test_stuck1();
        y_mode = 2;
        exp5   = 32'hFFFF_FFFE;
        pulse_start5();
        n_checks++;
        if (mm5 !== 6'd0 || ffv5 !== 1'b0 || table5 !== 32'h0) begin
            n_fail++;
            $display("FAIL stuck1_clear: mm=%0d ffv=%b table=%h, want 0 0 0", mm5, ffv5, table5);
        end
        step(64);
        n_checks++;
        if (done5 !== 1'b1 || pass5 !== 1'b0 || table5 !== 32'hFFFF_FFFF || mm5 !== 6'd1
            || ff5 !== 5'd0 || ffv5 !== 1'b1) begin
            n_fail++;
            $display("FAIL stuck1: done=%b pass=%b table=%h mm=%0d ff=%0d ffv=%b, want 1 0 ffffffff 1 0 1",
                     done5, pass5, table5, mm5, ff5, ffv5);
        end
        step(1);
    endtask

    task automatic test_small_settle3();
        int bad;
        exp3   = 8'h80;
        start3 = 1'b1;
        step(1);
        start3 = 1'b0;
        bad = 0;
        for (int k = 0; k < 32; k++) begin
            n_checks++;
            if (vec3 !== 3'(k >> 2) || done3 !== 1'b0) begin
                n_fail++;
                bad++;
                if (bad < 5)
                    $display("FAIL small_walk cyc %0d: vec=%0d done=%b, want vec=%0d done=0", k, vec3, done3, k >> 2);
            end
            step(1);
        end
        n_checks++;
        if (done3 !== 1'b1 || pass3 !== 1'b1 || table3 !== 8'h80 || mm3 !== 4'd0 || ffv3 !== 1'b0) begin
            n_fail++;
            $display("FAIL small_done: done=%b pass=%b table=%h mm=%0d ffv=%b, want 1 1 80 0 0",
                     done3, pass3, table3, mm3, ffv3);
        end
        step(1);
    endtask

    task automatic test_start_abort();
        int seen_done;
        y_mode = 0;
        exp5   = 32'h9669_6996;
        pulse_start5();
        step(10);
        start5 = 1'b1;
        step(1);
        start5 = 1'b0;
        n_checks++;
        if (vec5 !== 5'd5 || busy5 !== 1'b1) begin
            n_fail++;
            $display("FAIL restart_ignored_a: vec=%0d busy=%b, want 5 1", vec5, busy5);
        end
        step(1);
        n_checks++;
        if (vec5 !== 5'd6) begin
            n_fail++;
            $display("FAIL restart_ignored_b: vec=%0d, want 6", vec5);
        end
        step(2);
        abort5 = 1'b1;
        step(1);
        abort5 = 1'b0;
        n_checks++;
        if (busy5 !== 1'b0 || vec5 !== 5'd0 || pass5 !== 1'b0 || done5 !== 1'b0) begin
            n_fail++;
            $display("FAIL abort: busy=%b vec=%0d pass=%b done=%b, want 0 0 0 0", busy5, vec5, pass5, done5);
        end
        seen_done = 0;
        for (int k = 0; k < 70; k++) begin
            if (done5 === 1'b1 || busy5 === 1'b1) seen_done++;
            step(1);
        end
        n_checks++;
        if (seen_done != 0) begin
            n_fail++;
            $display("FAIL abort_quiet: %0d cycles with done/busy high, want 0", seen_done);
        end
        start5 = 1'b1;
        abort5 = 1'b1;
        step(1);
        start5 = 1'b0;
        abort5 = 1'b0;
        n_checks++;
        if (busy5 !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_wins: busy=%b, want 0", busy5);
        end
        pulse_start5();
        step(64);
        n_checks++;
        if (done5 !== 1'b1 || pass5 !== 1'b1 || table5 !== 32'h9669_6996 || mm5 !== 6'd0) begin
            n_fail++;
            $display("FAIL post_abort_sweep: done=%b pass=%b table=%h mm=%0d, want 1 1 96696996 0",
                     done5, pass5, table5, mm5);
        end
        step(1);
    endtask

    task automatic test_reset_mid_sweep();
        y_mode = 0;
        exp5   = 32'h9669_6996;
        pulse_start5();
        step(20);
        n_checks++;
        if (vec5 !== 5'd10) begin
            n_fail++;
            $display("FAIL mid_pre: vec=%0d, want 10", vec5);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({vec5, busy5, done5, pass5, table5, mm5, ff5, ffv5} !== '0) begin
            n_fail++;
            $display("FAIL mid_reset: vec=%0d busy=%b table=%h mm=%0d, want all 0", vec5, busy5, table5, mm5);
        end
        step(1);
        rst_n = 1'b1;
        step(1);
        pulse_start5();
        n_checks++;
        if (vec5 !== 5'd0 || busy5 !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_restart: vec=%0d busy=%b, want 0 1", vec5, busy5);
        end
        step(64);
        n_checks++;
        if (done5 !== 1'b1 || pass5 !== 1'b1 || table5 !== 32'h9669_6996) begin
            n_fail++;
            $display("FAIL mid_resweep: done=%b pass=%b table=%h, want 1 1 96696996", done5, pass5, table5);
        end
        step(1);
    endtask

    initial begin
        rst_n  = 1'b0;
        start5 = 1'b0; abort5 = 1'b0; exp5 = '0; y_mode = 0;
        start3 = 1'b0; abort3 = 1'b0; exp3 = '0;
        step(2);
        test_reset();
        rst_n = 1'b1;
        step(1);
        test_xor_sweep();
        test_stuck0();
        test_stuck1();
        test_small_settle3();
        test_start_abort();
        test_reset_mid_sweep();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cf_sweep_ctrl.md
Name: cf_sweep_ctrl

Overview:
Sequencer that exhaustively exercises a 5-input combinational function block in-system. It walks all 2^N_IN input vectors and waits a programmable settle time per vector. It then samples the block's output into a truth-table register and compares it against an expected table, reporting pass/fail, mismatch count and first failing vector. It sits beside the function block as a built-in self-check engine, started by a host strobe.

Parameters:
N_IN, 5, number of function inputs; sweep length = 2^N_IN vectors (legal 1..5)
SETTLE, 1, cycles a vector is held before sampling (legal 1..15)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  one-cycle request to begin a sweep; honoured only in IDLE
abort  input  1  synchronous cancel; returns to IDLE from any state
expected  input  2^N_IN  expected truth table; bit i = expected output for vector i; sampled per vector, must be stable while busy
y_in  input  1  output of the function block under control
vec_out  output  N_IN  input vector driven to the function block; vec_out[N_IN-1] is the slowest-changing input
busy  output  1  high from start acceptance until DONE is entered
done  output  1  one-cycle pulse at sweep completion
pass  output  1  1 = all samples matched expected; valid after done, held until next start
table_out  output  2^N_IN  captured truth table; bit i = y_in sampled for vector i
mismatch_cnt  output  N_IN+1  number of mismatching vectors (saturation impossible: max 2^N_IN)
first_fail  output  N_IN  index of lowest mismatching vector
first_fail_valid  output  1  first_fail holds a valid index

Behaviour:
- One clock and asynchronous active-low reset. rst_n low: state=IDLE. vec_out, table_out, mismatch_cnt and first_fail are 0. busy, done, pass and first_fail_valid are 0. Reset takes effect immediately, including mid-sweep. No partial result survives.
- The FSM has four states: IDLE, WAIT, SAMPLE and DONE.
- IDLE, start=1, abort=0: at the next edge, vec_out=0 and settle counter=SETTLE-1. table_out, mismatch_cnt and first_fail_valid are cleared, pass is cleared, busy=1, and the FSM enters WAIT.
- WAIT: counter decrements each cycle. When the counter is 0, go to SAMPLE. The vector is held for exactly SETTLE cycles before SAMPLE.
- SAMPLE: at the edge ending this cycle:
  - table_out[vec_out] <= y_in.
  - If y_in != expected[vec_out]: mismatch_cnt increments. If first_fail_valid=0, first_fail <= vec_out and first_fail_valid <= 1.
  - If vec_out = 2^N_IN-1: go to DONE. Otherwise vec_out increments, the counter reloads to SETTLE-1, and the FSM returns to WAIT.
- DONE lasts one cycle: done=1, busy=0, and pass = (mismatch_cnt==0) including the final sample. The next state is IDLE. vec_out returns to 0 on the DONE->IDLE edge.
- Timing: a vector occupies SETTLE+1 cycles. If start is sampled at edge T0, done is high in the cycle after edge T0 + 2^N_IN*(SETTLE+1). For defaults, that is edge T0+64.
- start while busy or in DONE: ignored, with no restart and no queueing.
- abort=1 in any state other than IDLE: the FSM enters IDLE at the next edge and vec_out=0. busy=0, done is not pulsed and pass=0. table_out, mismatch_cnt and first_fail keep their partial values and are not valid.
- abort and start both high in IDLE: abort wins and the sweep does not start.
- Results hold in IDLE until the next accepted start or reset.
- vec_out does not wrap: the sweep terminates at the all-ones vector.

Test Plan:
- Reset mid-sweep: assert rst_n=0 during vector 10. All outputs go to 0 immediately. Release rst_n, then start: the sweep restarts at vec_out=0.
- Defaults, y_in = XOR of vec_out bits, expected=0x96696996, start at T0. The bench must observe:
  - Vectors 0..31 each held 2 cycles.
  - done pulses once at T0+64.
  - pass=1, table_out=0x96696996, mismatch_cnt=0 and first_fail_valid=0.
- y_in stuck at 0, expected=0x96696996: pass=0, table_out=0, mismatch_cnt=16, first_fail=1 and first_fail_valid=1.
- y_in stuck at 1, expected=0xFFFFFFFE: pass=0, table_out=0xFFFFFFFF, mismatch_cnt=1 and first_fail=0.
- SETTLE=3, N_IN=3, y_in = AND of vec_out bits, expected=0x80: each vector is held 3 cycles in WAIT plus 1 in SAMPLE. done fires at T0+32 with pass=1 and table_out=0x80.
- Start pulse at vector 5 is ignored. Abort at vector 7: busy drops next cycle, done is never asserted, pass=0, vec_out=0. A following start runs a full clean sweep.
